// File: rtl/uart_echo_bridge.sv
// Echo bridge between the UART receiver and transmitter: receive handshake -> byte FIFO
// (optional CR -> CR-LF expansion) -> transmit launch paced on tx_busy.
module uart_echo_bridge #(
  parameter int FIFO_DEPTH   = 8,
  parameter int CRLF_EXPAND  = 1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            rx_ready,
  input  logic [7:0]                      rx_data,
  output logic                            rx_ready_clr,
  input  logic                            tx_busy,
  output logic                            tx_en,
  output logic [7:0]                      tx_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic {I_IDLE, I_WAIT_LOW} ingest_state_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT_BUSY, T_WAIT_DONE} drain_state_t;

  ingest_state_t istate_reg, istate_next;
  drain_state_t  tstate_reg, tstate_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          rx_ready_clr_reg, tx_en_reg, overflow_reg;
  logic [7:0]    tx_data_reg;

  logic          take, is_cr, fits, push_one, push_two, drop, launch;
  logic [CW-1:0] need, free, push_n;

  // Space is judged against the registered count, so a same-cycle pop never makes room.
  always_comb begin
    take     = (istate_reg == I_IDLE) && rx_ready;
    is_cr    = (CRLF_EXPAND != 0) && (rx_data == 8'h0D);
    need     = is_cr ? CW'(2) : CW'(1);
    free     = CW'(FIFO_DEPTH) - count_reg;
    fits     = (free >= need);
    push_one = take && fits && !is_cr;
    push_two = take && fits && is_cr;
    drop     = take && !fits;
    launch   = (tstate_reg == T_IDLE) && (count_reg != '0) && enable && !tx_busy;
    push_n   = push_two ? CW'(2) : (push_one ? CW'(1) : CW'(0));
    count_next = count_reg + push_n - {{(CW-1){1'b0}}, launch};
  end

  always_comb begin
    istate_next = istate_reg;
    case (istate_reg)
      I_IDLE:     if (rx_ready) istate_next = I_WAIT_LOW;
      I_WAIT_LOW: if (!rx_ready) istate_next = I_IDLE;
      default:    istate_next = I_IDLE;
    endcase
  end

  always_comb begin
    tstate_next = tstate_reg;
    tcnt_next   = tcnt_reg;
    case (tstate_reg)
      T_IDLE: begin
        if (launch) begin
          tstate_next = T_WAIT_BUSY;
          tcnt_next   = '0;
        end
      end
      T_WAIT_BUSY: begin
        if (tx_busy) tstate_next = T_WAIT_DONE;
        else if (tcnt_reg == TW'(BUSY_TIMEOUT - 1)) tstate_next = T_IDLE;
        else tcnt_next = tcnt_reg + TW'(1);
      end
      T_WAIT_DONE: if (!tx_busy) tstate_next = T_IDLE;
      default:     tstate_next = T_IDLE;
    endcase
  end

  // Storage array carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_one || push_two) mem[wr_ptr_reg] <= rx_data;
    if (push_two) mem[wr_ptr_reg + AW'(1)] <= 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      istate_reg       <= I_IDLE;
      tstate_reg       <= T_IDLE;
      tcnt_reg         <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      rx_ready_clr_reg <= 1'b0;
      tx_en_reg        <= 1'b0;
      tx_data_reg      <= 8'h00;
      overflow_reg     <= 1'b0;
    end else begin
      istate_reg       <= istate_next;
      tstate_reg       <= tstate_next;
      tcnt_reg         <= tcnt_next;
      count_reg        <= count_next;
      rx_ready_clr_reg <= take;
      tx_en_reg        <= launch;
      if (push_one) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (push_two) wr_ptr_reg <= wr_ptr_reg + AW'(2);
      if (launch) begin
        tx_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign rx_ready_clr = rx_ready_clr_reg;
  assign tx_en        = tx_en_reg;
  assign tx_data      = tx_data_reg;
  assign fifo_count   = count_reg;
  assign overflow     = overflow_reg;

endmodule

// File: doc/uart_echo_bridge.md
# uart_echo_bridge

Byte-level responder that sits between the UART receiver and transmitter inside the UART top level. It consumes bytes from the receiver's `ready`/`data_out` handshake, buffers them in a small FIFO with optional CR→CR-LF expansion, and drives them into the transmitter's `data_en`/`data_in` interface, pacing on `tx_busy`. The result is a hardware echo path for board bring-up, with occupancy and overflow visible for debug LEDs.

## Interface
- `FIFO_DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `CRLF_EXPAND`, 1: when 1, a received 0x0D is pushed as 0x0D then 0x0A.
- `BUSY_TIMEOUT`, 4: cycles to wait for `tx_busy` to rise after a launch before giving up.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level; 0 blocks new transmit launches. Ingest continues.
- `rx_ready` in 1: receiver byte-valid level.
- `rx_data` in 8: receiver byte; valid while `rx_ready`=1.
- `rx_ready_clr` out 1: one-cycle pulse acknowledging the byte to the receiver.
- `tx_busy` in 1: transmitter busy level.
- `tx_en` out 1: one-cycle launch pulse to the transmitter.
- `tx_data` out 8: byte to transmit; held stable from launch until the next launch.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy, 0..FIFO_DEPTH.
- `overflow` out 1: sticky; set when a byte is dropped. Cleared only by `rst`.

## Operation
- Reset: `rx_ready_clr`=0, `tx_en`=0, `tx_data`=0x00, `fifo_count`=0, `overflow`=0. FIFO is emptied and both FSMs enter their idle states. A reset during a transmit discards the in-flight byte and all buffered bytes.
- Ingest FSM, states I_IDLE and I_WAIT_LOW:
  - I_IDLE: on `rx_ready`=1, capture `rx_data`, pulse `rx_ready_clr`, then go to I_WAIT_LOW.
  - I_WAIT_LOW: stay until `rx_ready`=0, then return to I_IDLE. No byte is ever taken twice.
- Push rule:
  - The required space is 2 if `CRLF_EXPAND`=1 and the byte is 0x0D; otherwise it is 1.
  - Free space = FIFO_DEPTH − `fifo_count`, evaluated before any same-cycle pop. This check is conservative.
  - If space is insufficient, the whole byte is dropped (no partial CR-LF), `overflow` is set, and `rx_ready_clr` still pulses.
  - The two bytes of a CR-LF expansion are written in the same cycle, in order 0x0D then 0x0A.
- FIFO: circular buffer. Read and write pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop are both performed, so `fifo_count` changes by (pushed − 1).
- Drain FSM, states T_IDLE, T_WAIT_BUSY, T_WAIT_DONE:
  - T_IDLE: if `fifo_count`>0, `enable`=1 and `tx_busy`=0, load the head into `tx_data`, pulse `tx_en`, pop, and go to T_WAIT_BUSY.
  - T_WAIT_BUSY: when `tx_busy`=1, go to T_WAIT_DONE. After BUSY_TIMEOUT cycles without `tx_busy`, go to T_IDLE.
  - T_WAIT_DONE: when `tx_busy`=0, go to T_IDLE.
- Deasserting `enable` mid-byte does not abort the byte; it only blocks the next launch.

## Timing
- All outputs are registered.
- Ingest: if `rx_ready`=1 is sampled in I_IDLE at edge N, then `rx_ready_clr`=1 during cycle N+1 only, and `fifo_count` reflects the push in cycle N+1.
- Drain: if the launch condition is sampled at edge M, then `tx_en`=1 and the new `tx_data` are present during cycle M+1 only.
- Minimum latency from `rx_ready` rising to `tx_en` is 2 cycles, when the FIFO is empty and the transmitter is idle.
- Minimum spacing between `tx_en` pulses is 3 cycles: launch, busy-rise, and busy-fall observed.
- `overflow` is set in the same cycle as the suppressed push.

## Test plan
- Single echo:
  - After reset, check all outputs are zero.
  - Present 0x41 on `rx_data` with `rx_ready`.
  - Required: `rx_ready_clr` pulses for exactly 1 cycle.
  - Required: `tx_en` pulses 2 cycles after `rx_ready` rises, with `tx_data`=0x41, and `fifo_count` returns to 0.
- CR expansion:
  - With `CRLF_EXPAND`=1, receive 0x0D while `tx_busy` is held high.
  - Required: `fifo_count`=2.
  - Required: after `tx_busy` is released, bytes 0x0D then 0x0A are launched in order.
- Overflow and wrap:
  - With DEPTH=8 and `enable`=0, receive 7 bytes 0x01..0x07, then 0x0D, then 0x08.
  - Required: 0x0D is dropped whole and `overflow`=1.
  - Required: 0x08 is accepted, `fifo_count`=8, then 0x09 is dropped.
  - Set `enable`=1. Required: 0x01..0x08 are launched in order. Pointers wrap, verified by a further 10-byte stream arriving intact.
- Simultaneous push and pop:
  - Align an `rx_ready` capture with a launch cycle.
  - Required: `fifo_count` is unchanged and order is preserved.
- Busy timeout and reset:
  - Transmitter model never raises `tx_busy`. Required: the FSM returns to T_IDLE after 4 cycles and launches the next byte.
  - Assert `rst` mid-stream. Required: all outputs and `fifo_count` are 0 on the next cycle and the sticky `overflow` is cleared.
